decode_hazard_stage: RTL and testbench

//  Parametrised ID stage of the 5-stage pipeline: decodes the IF/ID instruction, registers control
//  and operand fields into the ID/EX register, detects load-use hazards (inserts one bubble),

---
 rtl/decode_hazard_stage.sv | 176 +++++++++++++++++
 tb/tb_decode_hazard_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/decode_hazard_stage.sv
// ID stage: decodes IF/ID, registers ID/EX, inserts a bubble on load-use hazards,
// honours EX flush and back-pressure, latches HALT and counts stalled cycles.
module decode_hazard_stage #(
    parameter int unsigned OPCODE_WIDTH   = 4,
    parameter int unsigned REG_ADDR_WIDTH = 3,
    parameter int unsigned IMM_WIDTH      = 6,
    parameter int unsigned INSTR_WIDTH    = 16,
    parameter int unsigned ALU_OP_WIDTH   = 4,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_valid,
    input  logic [INSTR_WIDTH-1:0]    if_instr,
    output logic                      id_ready,
    input  logic                      ex_ready,
    input  logic                      ex_flush,
    output logic                      ex_valid,
    output logic                      ex_reg_write,
    output logic                      ex_mem_write,
    output logic                      ex_load,
    output logic                      ex_use_imm,
    output logic                      ex_mem_addr_sel,
    output logic                      ex_is_branch,
    output logic                      ex_is_jump,
    output logic [ALU_OP_WIDTH-1:0]   ex_alu_op,
    output logic [REG_ADDR_WIDTH-1:0] ex_rs1,
    output logic [REG_ADDR_WIDTH-1:0] ex_rs2,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic [IMM_WIDTH-1:0]      ex_imm,
    output logic                      halted,
    output logic [CNT_WIDTH-1:0]      stall_count
);

    if (INSTR_WIDTH != OPCODE_WIDTH + 2 * REG_ADDR_WIDTH + IMM_WIDTH) begin : g_width_check
        $error("INSTR_WIDTH must equal OPCODE_WIDTH + 2*REG_ADDR_WIDTH + IMM_WIDTH");
    end

    typedef enum logic [3:0] {
        OP_LOADI = 4'h0, OP_ADD  = 4'h1, OP_SUB  = 4'h2, OP_AND  = 4'h3,
        OP_OR    = 4'h4, OP_XOR  = 4'h5, OP_STORE= 4'h6, OP_LOAD = 4'h7,
        OP_SHL   = 4'h8, OP_SHR  = 4'h9, OP_MOV  = 4'hA, OP_CMP  = 4'hB,
        OP_JUMP  = 4'hC, OP_JZ   = 4'hD, OP_JNZ  = 4'hE, OP_HALT = 4'hF
    } opcode_e;

    typedef struct packed {
        logic                      reg_write;
        logic                      mem_write;
        logic                      load;
        logic                      use_imm;
        logic                      addr_sel;
        logic                      is_branch;
        logic                      is_jump;
        logic [ALU_OP_WIDTH-1:0]   alu_op;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [IMM_WIDTH-1:0]      imm;
    } idex_t;

    logic [OPCODE_WIDTH-1:0]   opcode;
    logic [REG_ADDR_WIDTH-1:0] f_rs1, f_rs2;
    logic                      op_known, reads_rs1, reads_rs2, is_halt, hazard;
    opcode_e                   op;
    idex_t                     dec, ex_q, ex_d;
    logic                      ex_valid_q, ex_valid_d, halted_q, halted_d;
    logic [CNT_WIDTH-1:0]      stall_q, stall_d;

    assign opcode   = if_instr[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign f_rs1    = if_instr[INSTR_WIDTH-OPCODE_WIDTH-1 -: REG_ADDR_WIDTH];
    assign f_rs2    = if_instr[INSTR_WIDTH-OPCODE_WIDTH-REG_ADDR_WIDTH-1 -: REG_ADDR_WIDTH];
    assign op_known = (opcode >> 4) == '0;
    assign op       = opcode_e'(4'(opcode));

    always_comb begin
        dec       = '0;
        dec.rs1   = f_rs1;
        dec.rs2   = f_rs2;
        dec.imm   = if_instr[IMM_WIDTH-1:0];
        reads_rs1 = 1'b0;
        reads_rs2 = 1'b0;
        is_halt   = 1'b0;
        if (op_known) begin
            case (op)
                OP_LOADI: begin
                    dec.reg_write = 1'b1; dec.rd = f_rs1; dec.use_imm = 1'b1;
                    dec.alu_op = ALU_OP_WIDTH'(4'b1101);
                end
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
                    dec.reg_write = 1'b1; dec.rd = f_rs2;
                    reads_rs1 = 1'b1; reads_rs2 = 1'b1;
                    case (op)
                        OP_ADD:  dec.alu_op = ALU_OP_WIDTH'(4'b0000);
                        OP_SUB:  dec.alu_op = ALU_OP_WIDTH'(4'b0001);
                        OP_AND:  dec.alu_op = ALU_OP_WIDTH'(4'b0010);
                        OP_OR:   dec.alu_op = ALU_OP_WIDTH'(4'b0011);
                        OP_XOR:  dec.alu_op = ALU_OP_WIDTH'(4'b0100);
                        OP_SHL:  dec.alu_op = ALU_OP_WIDTH'(4'b0110);
                        default: dec.alu_op = ALU_OP_WIDTH'(4'b0111);
                    endcase
                end
                OP_STORE: begin
                    dec.mem_write = 1'b1; dec.addr_sel = 1'b1; reads_rs1 = 1'b1;
                end
                OP_LOAD: begin
                    dec.reg_write = 1'b1; dec.load = 1'b1; dec.addr_sel = 1'b1; dec.rd = f_rs1;
                end
                OP_MOV: begin
                    dec.reg_write = 1'b1; dec.rd = f_rs2; reads_rs1 = 1'b1;
                    dec.alu_op = ALU_OP_WIDTH'(4'b1100);
                end
                OP_CMP: begin
                    dec.alu_op = ALU_OP_WIDTH'(4'b0001); reads_rs1 = 1'b1; reads_rs2 = 1'b1;
                end
                OP_JUMP: dec.is_jump = 1'b1;
                OP_JZ, OP_JNZ: begin
                    dec.is_branch = 1'b1; dec.use_imm = 1'b1; reads_rs1 = 1'b1;
                    dec.alu_op = ALU_OP_WIDTH'(4'b0001);
                end
                default: is_halt = 1'b1;
            endcase
        end
    end

    assign hazard = ex_valid_q && ex_q.load &&
                    ((reads_rs1 && f_rs1 == ex_q.rd) || (reads_rs2 && f_rs2 == ex_q.rd));

    // Priority: flush > back-pressure > hazard > accept; halted blocks acceptance outright.
    assign id_ready = if_valid && !rst && !halted_q && !ex_flush && ex_ready && !hazard;

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_d       = ex_q;
        halted_d   = halted_q;
        stall_d    = stall_q;
        if (ex_flush) begin
            ex_valid_d = 1'b0;
        end else if (ex_ready) begin
            ex_valid_d = id_ready;
            if (id_ready) ex_d = dec;
        end
        if (id_ready && is_halt) halted_d = 1'b1;
        if (if_valid && !id_ready && stall_q != '1) stall_d = stall_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
            halted_q   <= 1'b0;
            stall_q    <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_q       <= ex_d;
            halted_q   <= halted_d;
            stall_q    <= stall_d;
        end
    end

    assign ex_valid        = ex_valid_q;
    assign ex_reg_write    = ex_q.reg_write;
    assign ex_mem_write    = ex_q.mem_write;
    assign ex_load         = ex_q.load;
    assign ex_use_imm      = ex_q.use_imm;
    assign ex_mem_addr_sel = ex_q.addr_sel;
    assign ex_is_branch    = ex_q.is_branch;
    assign ex_is_jump      = ex_q.is_jump;
    assign ex_alu_op       = ex_q.alu_op;
    assign ex_rs1          = ex_q.rs1;
    assign ex_rs2          = ex_q.rs2;
    assign ex_rd           = ex_q.rd;
    assign ex_imm          = ex_q.imm;
    assign halted          = halted_q;
    assign stall_count     = stall_q;

endmodule

// File: tb/tb_decode_hazard_stage.sv
// Directed bench for decode_hazard_stage: expected ID/EX entries are queued at issue
// and popped when they reach EX; stall counter uses a narrow width to reach saturation.
module tb_decode_hazard_stage;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, if_valid, ex_ready, ex_flush;
    logic [15:0]   if_instr;
    logic          id_ready, ex_valid, ex_reg_write, ex_mem_write, ex_load, ex_use_imm;
    logic          ex_mem_addr_sel, ex_is_branch, ex_is_jump, halted;
    logic [3:0]    ex_alu_op;
    logic [2:0]    ex_rs1, ex_rs2, ex_rd;
    logic [5:0]    ex_imm;
    logic [CW-1:0] stall_count;

    decode_hazard_stage #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .id_ready(id_ready),
        .ex_ready(ex_ready), .ex_flush(ex_flush), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write), .ex_load(ex_load),
        .ex_use_imm(ex_use_imm), .ex_mem_addr_sel(ex_mem_addr_sel),
        .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_alu_op(ex_alu_op),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_imm(ex_imm),
        .halted(halted), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       wr, mw, ld, ui, as, br, jp, alu_chk;
        logic [3:0] alu;
        logic [2:0] rs1, rs2, rd;
        logic [5:0] imm;
    } exp_t;

    exp_t          sb[$];
    exp_t          cur;
    int            tests = 0;
    int            fails = 0;
    logic          m_valid, m_halted, m_halt_next;
    logic [CW-1:0] m_stall;

    function automatic logic [15:0] mk(int op, int r1, int r2, int imm);
        return {4'(op), 3'(r1), 3'(r2), 6'(imm)};
    endfunction

    function automatic exp_t model(logic [15:0] ins);
        exp_t e = '0;
        e.rs1 = ins[11:9]; e.rs2 = ins[8:6]; e.imm = ins[5:0];
        case (ins[15:12])
            4'h0: begin e.wr = 1; e.rd = ins[11:9]; e.ui = 1; e.alu = 4'b1101; e.alu_chk = 1; end
            4'h1: begin e.wr = 1; e.rd = ins[8:6]; e.alu = 4'b0000; e.alu_chk = 1; end
            4'h2: begin e.wr = 1; e.rd = ins[8:6]; e.alu = 4'b0001; e.alu_chk = 1; end
            4'h3: begin e.wr = 1; e.rd = ins[8:6]; e.alu = 4'b0010; e.alu_chk = 1; end
            4'h4: begin e.wr = 1; e.rd = ins[8:6]; e.alu = 4'b0011; e.alu_chk = 1; end
            4'h5: begin e.wr = 1; e.rd = ins[8:6]; e.alu = 4'b0100; e.alu_chk = 1; end
            4'h6: begin e.mw = 1; e.as = 1; end
            4'h7: begin e.wr = 1; e.ld = 1; e.as = 1; e.rd = ins[11:9]; end
            4'h8: begin e.wr = 1; e.rd = ins[8:6]; e.alu = 4'b0110; e.alu_chk = 1; end
            4'h9: begin e.wr = 1; e.rd = ins[8:6]; e.alu = 4'b0111; e.alu_chk = 1; end
            4'hA: begin e.wr = 1; e.rd = ins[8:6]; e.alu = 4'b1100; e.alu_chk = 1; end
            4'hB: begin e.alu = 4'b0001; e.alu_chk = 1; end
            4'hC: e.jp = 1;
            4'hD, 4'hE: begin e.br = 1; e.ui = 1; e.alu = 4'b0001; e.alu_chk = 1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".ex_valid"}, 32'(ex_valid), 32'(m_valid));
        chk({tag, ".halted"}, 32'(halted), 32'(m_halted));
        chk({tag, ".stall_count"}, 32'(stall_count), 32'(m_stall));
        if (m_valid) begin
            chk({tag, ".reg_write"}, 32'(ex_reg_write), 32'(cur.wr));
            chk({tag, ".mem_write"}, 32'(ex_mem_write), 32'(cur.mw));
            chk({tag, ".load"}, 32'(ex_load), 32'(cur.ld));
            chk({tag, ".use_imm"}, 32'(ex_use_imm), 32'(cur.ui));
            chk({tag, ".addr_sel"}, 32'(ex_mem_addr_sel), 32'(cur.as));
            chk({tag, ".is_branch"}, 32'(ex_is_branch), 32'(cur.br));
            chk({tag, ".is_jump"}, 32'(ex_is_jump), 32'(cur.jp));
            chk({tag, ".rs1"}, 32'(ex_rs1), 32'(cur.rs1));
            chk({tag, ".rs2"}, 32'(ex_rs2), 32'(cur.rs2));
            chk({tag, ".imm"}, 32'(ex_imm), 32'(cur.imm));
            if (cur.wr) chk({tag, ".rd"}, 32'(ex_rd), 32'(cur.rd));
            if (cur.alu_chk) chk({tag, ".alu_op"}, 32'(ex_alu_op), 32'(cur.alu));
        end
    endtask

    // One clock: drive inputs, check id_ready, then check the registered result after the edge.
    task automatic cyc(input string tag, input logic v, input logic [15:0] ins,
                       input logic rdy, input logic fl, input logic exp_rdy);
        if_valid = v; if_instr = ins; ex_ready = rdy; ex_flush = fl;
        #1;
        chk({tag, ".id_ready"}, 32'(id_ready), 32'(exp_rdy));
        if (exp_rdy) begin
            sb.push_back(model(ins));
            if (ins[15:12] == 4'hF) m_halt_next = 1'b1;
        end
        if (v && !exp_rdy && m_stall != '1) m_stall = m_stall + 1'b1;
        @(posedge clk); #1;
        if (fl) m_valid = 1'b0;
        else if (rdy) begin
            m_valid = exp_rdy;
            if (exp_rdy) cur = sb.pop_front();
        end
        if (m_halt_next) m_halted = 1'b1;
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1; if_valid = 1'b1; if_instr = 16'h1280; ex_ready = 1'b1; ex_flush = 1'b0;
        #1;
        chk({tag, ".id_ready_in_rst"}, 32'(id_ready), 32'd0);
        @(posedge clk); #1;
        m_valid = 1'b0; m_halted = 1'b0; m_halt_next = 1'b0; m_stall = '0;
        sb.delete();
        check_state(tag);
        chk({tag, ".alu_op"}, 32'(ex_alu_op), 32'd0);
        chk({tag, ".rd"}, 32'(ex_rd), 32'd0);
        chk({tag, ".imm"}, 32'(ex_imm), 32'd0);
        chk({tag, ".reg_write"}, 32'(ex_reg_write), 32'd0);
        rst = 1'b0; if_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset("reset0");

        cyc("add_r1_r2", 1, 16'h1280, 1, 0, 1);

        cyc("load_r3", 1, mk(7, 3, 0, 5), 1, 0, 1);
        cyc("add_r3_hazard", 1, mk(1, 3, 4, 0), 1, 0, 0);
        cyc("add_r3_issue", 1, mk(1, 3, 4, 0), 1, 0, 1);

        cyc("load_r3_b", 1, mk(7, 3, 0, 1), 1, 0, 1);
        cyc("loadi_r3_nostall", 1, mk(0, 3, 0, 9), 1, 0, 1);

        cyc("load_r5", 1, mk(7, 5, 0, 2), 1, 0, 1);
        cyc("cmp_rs2_hazard", 1, mk(11, 1, 5, 0), 1, 0, 0);
        cyc("cmp_issue", 1, mk(11, 1, 5, 0), 1, 0, 1);

        cyc("load_r2", 1, mk(7, 2, 0, 0), 1, 0, 1);
        cyc("jump_nostall", 1, mk(12, 2, 2, 7), 1, 0, 1);

        for (int i = 0; i < 3; i++) cyc("backpressure", 1, mk(2, 1, 2, 0), 0, 0, 0);
        cyc("sub_after_bp", 1, mk(2, 1, 2, 0), 1, 0, 1);

        cyc("flush_sub", 1, mk(2, 6, 7, 0), 1, 1, 0);
        cyc("flush_halt", 1, mk(15, 0, 0, 0), 1, 1, 0);
        cyc("idle", 0, mk(1, 1, 1, 1), 1, 0, 0);

        cyc("and", 1, mk(3, 1, 2, 3), 1, 0, 1);
        cyc("or", 1, mk(4, 2, 3, 4), 1, 0, 1);
        cyc("xor", 1, mk(5, 3, 4, 5), 1, 0, 1);
        cyc("shl", 1, mk(8, 4, 5, 6), 1, 0, 1);
        cyc("shr", 1, mk(9, 5, 6, 7), 1, 0, 1);
        cyc("mov", 1, mk(10, 6, 7, 8), 1, 0, 1);
        cyc("store", 1, mk(6, 7, 1, 63), 1, 0, 1);
        cyc("jz", 1, mk(13, 1, 0, 33), 1, 0, 1);
        cyc("jnz", 1, mk(14, 2, 0, 34), 1, 0, 1);

        cyc("halt_accept", 1, mk(15, 0, 0, 0), 1, 0, 1);
        for (int i = 0; i < 12; i++) cyc("halted_stall", 1, 16'h1280, 1, 0, 0);
        cyc("halted_idle", 0, 16'h1280, 1, 0, 0);

        do_reset("reset_mid_halt");
        cyc("add_after_reset", 1, mk(1, 4, 5, 0), 1, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
